// File: rtl/wb_stage.sv
// wb_stage: pipeline writeback stage.
// Picks the register-file write data from ALU, PC+4 or load data and issues a
// registered rf_we/rf_wa/rf_wd write. It stalls execute (ex_ready = 0) while a
// load waits for its data-memory response.
// Optional feature macro: WB_LOAD_TIMEOUT_EN. When defined, a load waiting
// TIMEOUT cycles without dmem_rvalid is dropped and the sticky load_err is set.
module wb_stage #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [4:0]  ex_rd,
    input  logic        ex_rd_we,
    input  logic [1:0]  ex_wb_sel,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_alu,
    input  logic [31:0] ex_pc4,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd
`ifdef WB_LOAD_TIMEOUT_EN
    ,
    output logic        load_err
`endif
);

    // Catch a counter too narrow to ever reach TIMEOUT.
    if (TIMEOUT >= (2 ** TW)) begin : g_cfg_check
        $error("wb_stage: TW too small for TIMEOUT");
    end

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_t;

    state_t      state_reg, state_next;

    // Load context captured at accept time; execute may move on afterwards.
    logic [4:0]  rd_reg;
    logic        rd_we_reg;
    logic [2:0]  funct3_reg;
    logic [1:0]  off_reg;

    logic        load_accept;
    logic        timeout_hit;
    logic        wr_next;
    logic [4:0]  wa_next;
    logic [31:0] wd_next;
    logic [31:0] load_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [7:0]  rbyte [4];

    assign ex_ready    = (state_reg == IDLE);
    assign load_accept = ex_valid && ex_ready && (ex_wb_sel == 2'd2);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bytes
            assign rbyte[gi] = dmem_rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = rbyte[off_reg];
    assign half_sel = off_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    // Size/sign extraction of the returned word using the latched funct3/offset.
    always_comb begin
        load_data = dmem_rdata;
        case (funct3_reg)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = dmem_rdata;
        endcase
    end

`ifdef WB_LOAD_TIMEOUT_EN
    logic [TW-1:0] cnt_reg;

    // The abort edge is the one where the counter would reach TIMEOUT.
    assign timeout_hit = (cnt_reg == TW'(TIMEOUT - 1));

    // Wait counter and sticky error flag; rvalid takes priority over abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            load_err <= 1'b0;
        end else if (load_accept) begin
            cnt_reg <= '0;
        end else if (state_reg == WAIT_LOAD && !dmem_rvalid) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (timeout_hit) begin
                load_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next state and next write; address/data hold when no write is issued.
    always_comb begin
        state_next = state_reg;
        wr_next    = 1'b0;
        wa_next    = rf_wa;
        wd_next    = rf_wd;
        case (state_reg)
            IDLE: begin
                if (ex_valid) begin
                    if (ex_wb_sel == 2'd2) begin
                        state_next = WAIT_LOAD;
                    end else if (ex_rd_we && ex_rd != 5'd0) begin
                        wr_next = 1'b1;
                        wa_next = ex_rd;
                        wd_next = (ex_wb_sel == 2'd1) ? ex_pc4 : ex_alu;
                    end
                end
            end
            WAIT_LOAD: begin
                if (dmem_rvalid) begin
                    state_next = IDLE;
                    if (rd_we_reg && rd_reg != 5'd0) begin
                        wr_next = 1'b1;
                        wa_next = rd_reg;
                        wd_next = load_data;
                    end
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            rf_we     <= 1'b0;
            rf_wa     <= 5'd0;
            rf_wd     <= 32'd0;
        end else begin
            state_reg <= state_next;
            rf_we     <= wr_next;
            rf_wa     <= wa_next;
            rf_wd     <= wd_next;
        end
    end

    // Capture load context on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_reg     <= 5'd0;
            rd_we_reg  <= 1'b0;
            funct3_reg <= 3'd0;
            off_reg    <= 2'd0;
        end else if (load_accept) begin
            rd_reg     <= ex_rd;
            rd_we_reg  <= ex_rd_we;
            funct3_reg <= ex_funct3;
            off_reg    <= ex_alu[1:0];
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: self-checking bench for wb_stage.
// Table of single transactions, hand-written multi-cycle sequences and a
// randomized run checked against a behavioural load-extraction model.
// Build with WB_LOAD_TIMEOUT_EN defined to also cover the timeout feature.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [4:0]  ex_rd = '0;
    logic        ex_rd_we = 1'b0;
    logic [1:0]  ex_wb_sel = '0;
    logic [2:0]  ex_funct3 = '0;
    logic [31:0] ex_alu = '0;
    logic [31:0] ex_pc4 = '0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
`ifdef WB_LOAD_TIMEOUT_EN
    logic        load_err;
`endif

    wb_stage #(.TIMEOUT(3), .TW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_wb_sel(ex_wb_sel),
        .ex_funct3(ex_funct3), .ex_alu(ex_alu), .ex_pc4(ex_pc4),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
`ifdef WB_LOAD_TIMEOUT_EN
        , .load_err(load_err)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Model of the held write address/data (last issued write).
    logic [4:0]  m_wa = '0;
    logic [31:0] m_wd = '0;

    typedef struct packed {
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] rdata;
        logic [3:0]  delay;
        logic        exp_we;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b want %0b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load result from the architectural rules: shift, mask, then sign-adjust.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> (8 * off)) & 32'hFF;
        h = (d >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'b101:  return h;
            default: return d;
        endcase
    endfunction

    // One complete transaction: accept, optional load wait, write check, pulse end.
    task automatic do_txn(input vec_t v, input int id);
        ex_wb_sel = v.sel; ex_funct3 = v.f3; ex_rd = v.rd; ex_rd_we = v.rd_we;
        ex_alu = v.alu; ex_pc4 = v.pc4; ex_valid = 1'b1;
        chk_bit("ready_before", ex_ready, 1'b1);
        tick();
        ex_valid = 1'b0;
        if (v.sel == 2'd2) begin
            for (int i = 0; i < int'(v.delay); i++) begin
                chk_bit("ready_wait", ex_ready, 1'b0);
                chk_bit("we_wait", rf_we, 1'b0);
                tick();
            end
            dmem_rvalid = 1'b1;
            dmem_rdata = v.rdata;
            chk_bit("ready_rvalid", ex_ready, 1'b0);
            tick();
            dmem_rvalid = 1'b0;
            dmem_rdata = $urandom;
        end
        if (v.exp_we) begin
            m_wa = v.rd;
            m_wd = v.exp_wd;
        end
        chk_bit("rf_we", rf_we, v.exp_we);
        chk("rf_wa", {27'd0, rf_wa}, {27'd0, m_wa});
        chk("rf_wd", rf_wd, m_wd);
        chk_bit("ready_after", ex_ready, 1'b1);
        $display("txn %0d sel=%0d f3=%0d rd=%0d we=%0b wd=%08h", id, v.sel, v.f3, v.rd, rf_we, rf_wd);
        tick();
        chk_bit("we_pulse", rf_we, 1'b0);
    endtask

    initial begin
        // Stimulus table: sel, f3, rd, rd_we, alu, pc4, rdata, delay, exp_we, exp_wd
        vecs[0]  = '{2'd0, 3'd0, 5'd5,  1'b1, 32'h1234_5678, 32'h0, 32'h0, 4'd0, 1'b1, 32'h1234_5678};
        vecs[1]  = '{2'd2, 3'd0, 5'd10, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_7F01, 4'd0, 1'b1, 32'hFFFF_FF80};
        vecs[2]  = '{2'd2, 3'd4, 5'd11, 1'b1, 32'h0000_1001, 32'h0, 32'h80FF_7F01, 4'd1, 1'b1, 32'h0000_007F};
        vecs[3]  = '{2'd2, 3'd1, 5'd12, 1'b1, 32'h0000_1002, 32'h0, 32'h80FF_7F01, 4'd0, 1'b1, 32'hFFFF_80FF};
        vecs[4]  = '{2'd2, 3'd2, 5'd13, 1'b1, 32'h0000_1000, 32'h0, 32'h80FF_7F01, 4'd2, 1'b1, 32'h80FF_7F01};
        vecs[5]  = '{2'd2, 3'd5, 5'd14, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_7F01, 4'd0, 1'b1, 32'h0000_80FF};
        vecs[6]  = '{2'd2, 3'd3, 5'd15, 1'b1, 32'h0000_1002, 32'h0, 32'h80FF_7F01, 4'd0, 1'b1, 32'h80FF_7F01};
        vecs[7]  = '{2'd3, 3'd0, 5'd16, 1'b1, 32'hCAFE_0003, 32'h5, 32'h0, 4'd0, 1'b1, 32'hCAFE_0003};
        vecs[8]  = '{2'd0, 3'd0, 5'd0,  1'b1, 32'h1111_1111, 32'h0, 32'h0, 4'd0, 1'b0, 32'h0};
        vecs[9]  = '{2'd2, 3'd2, 5'd0,  1'b1, 32'h0000_2000, 32'h0, 32'h5555_AAAA, 4'd1, 1'b0, 32'h0};
        vecs[10] = '{2'd0, 3'd0, 5'd7,  1'b0, 32'h2222_2222, 32'h0, 32'h0, 4'd0, 1'b0, 32'h0};
        vecs[11] = '{2'd2, 3'd0, 5'd17, 1'b1, 32'h0000_3001, 32'h0, 32'h80FF_7F01, 4'd0, 1'b1, 32'h0000_007F};

        // Reset state
        tick();
        chk_bit("rst_we", rf_we, 1'b0);
        chk("rst_wa", {27'd0, rf_wa}, 32'd0);
        chk("rst_wd", rf_wd, 32'd0);
        chk_bit("rst_ready", ex_ready, 1'b1);
`ifdef WB_LOAD_TIMEOUT_EN
        chk_bit("rst_err", load_err, 1'b0);
`endif
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            do_txn(vecs[i], i);
        end

        // Back-to-back PC+4 then ALU; rvalid in IDLE must be ignored
        ex_wb_sel = 2'd1; ex_rd = 5'd1; ex_rd_we = 1'b1; ex_pc4 = 32'h0000_0104;
        ex_alu = 32'h9999_0000; ex_valid = 1'b1; dmem_rvalid = 1'b1;
        tick();
        ex_wb_sel = 2'd0; ex_rd = 5'd2; ex_alu = 32'h0000_ABCD;
        chk_bit("b2b_we1", rf_we, 1'b1);
        chk("b2b_wa1", {27'd0, rf_wa}, 32'd1);
        chk("b2b_wd1", rf_wd, 32'h0000_0104);
        tick();
        ex_valid = 1'b0;
        chk_bit("b2b_we2", rf_we, 1'b1);
        chk("b2b_wa2", {27'd0, rf_wa}, 32'd2);
        chk("b2b_wd2", rf_wd, 32'h0000_ABCD);
        chk_bit("b2b_ready", ex_ready, 1'b1);
        tick();
        dmem_rvalid = 1'b0;
        chk_bit("b2b_end", rf_we, 1'b0);
        $display("seq b2b done");
        m_wa = 5'd2; m_wd = 32'h0000_ABCD;

        // Load stalled 4 cycles with a held ALU instruction behind it
        ex_wb_sel = 2'd2; ex_funct3 = 3'd0; ex_rd = 5'd6; ex_rd_we = 1'b1;
        ex_alu = 32'h0000_4003; ex_valid = 1'b1;
        tick();
        ex_wb_sel = 2'd0; ex_rd = 5'd9; ex_alu = 32'h0BAD_F00D;
        for (int i = 0; i < 4; i++) begin
            chk_bit("stall_ready", ex_ready, 1'b0);
            chk_bit("stall_we", rf_we, 1'b0);
            tick();
        end
        dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_7F01;
        tick();
        dmem_rvalid = 1'b0;
        chk_bit("stall_ld_we", rf_we, 1'b1);
        chk("stall_ld_wa", {27'd0, rf_wa}, 32'd6);
        chk("stall_ld_wd", rf_wd, 32'hFFFF_FF80);
        chk_bit("stall_ready_back", ex_ready, 1'b1);
        tick();
        ex_valid = 1'b0;
        chk_bit("stall_alu_we", rf_we, 1'b1);
        chk("stall_alu_wa", {27'd0, rf_wa}, 32'd9);
        chk("stall_alu_wd", rf_wd, 32'h0BAD_F00D);
        tick();
        chk_bit("stall_end", rf_we, 1'b0);
        $display("seq stall done");
        m_wa = 5'd9; m_wd = 32'h0BAD_F00D;

        // Randomized transactions against the model
        for (int i = 0; i < 60; i++) begin
            vec_t v;
            v.sel = 2'($urandom_range(0, 3));
            v.f3 = 3'($urandom_range(0, 7));
            v.rd = 5'($urandom_range(0, 31));
            v.rd_we = ($urandom_range(0, 3) != 0);
            v.alu = $urandom;
            v.pc4 = $urandom;
            v.rdata = $urandom;
            v.delay = 4'($urandom_range(0, 3));
            v.exp_we = v.rd_we && (v.rd != 5'd0);
            if (v.sel == 2'd1) v.exp_wd = v.pc4;
            else if (v.sel == 2'd2) v.exp_wd = ref_load(v.f3, v.alu[1:0], v.rdata);
            else v.exp_wd = v.alu;
            do_txn(v, 100 + i);
        end

`ifdef WB_LOAD_TIMEOUT_EN
        // rvalid on the cycle the counter would reach TIMEOUT wins
        ex_wb_sel = 2'd2; ex_funct3 = 3'd2; ex_rd = 5'd20; ex_rd_we = 1'b1;
        ex_alu = 32'h0; ex_valid = 1'b1;
        tick();
        ex_valid = 1'b0;
        tick();
        tick();
        dmem_rvalid = 1'b1; dmem_rdata = 32'h7777_0001;
        tick();
        dmem_rvalid = 1'b0;
        chk_bit("to_win_we", rf_we, 1'b1);
        chk("to_win_wd", rf_wd, 32'h7777_0001);
        chk_bit("to_win_err", load_err, 1'b0);
        m_wa = 5'd20; m_wd = 32'h7777_0001;
        tick();

        // No rvalid: abort after 3 wait cycles, sticky error, no write
        ex_rd = 5'd21; ex_valid = 1'b1;
        tick();
        ex_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_bit("to_ready", ex_ready, 1'b0);
            chk_bit("to_err_early", load_err, 1'b0);
            tick();
        end
        chk_bit("to_ready_back", ex_ready, 1'b1);
        chk_bit("to_err", load_err, 1'b1);
        chk_bit("to_we", rf_we, 1'b0);
        chk("to_wd_hold", rf_wd, m_wd);
        tick();
        tick();
        chk_bit("to_err_sticky", load_err, 1'b1);
        $display("seq timeout done");
`endif

        // Reset pulsed mid-WAIT_LOAD clears outputs and drops the load
        ex_wb_sel = 2'd2; ex_funct3 = 3'd2; ex_rd = 5'd22; ex_rd_we = 1'b1;
        ex_alu = 32'h0; ex_valid = 1'b1;
        tick();
        ex_valid = 1'b0;
        chk_bit("mid_ready", ex_ready, 1'b0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk_bit("mid_rst_we", rf_we, 1'b0);
        chk("mid_rst_wa", {27'd0, rf_wa}, 32'd0);
        chk("mid_rst_wd", rf_wd, 32'd0);
        chk_bit("mid_rst_ready", ex_ready, 1'b1);
`ifdef WB_LOAD_TIMEOUT_EN
        chk_bit("mid_rst_err", load_err, 1'b0);
`endif
        tick();
        rst_n = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1357_2468;
        tick();
        dmem_rvalid = 1'b0;
        chk_bit("mid_drop_we", rf_we, 1'b0);
        chk("mid_drop_wd", rf_wd, 32'd0);
        $display("seq reset-mid-load done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
